// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adc_scan_sequencer
// Brief    : Round-robin LTC2308 channel scanner with one-frame result latency
//            correction and a one-entry valid/ack sample buffer.
// Revision : 1.0 - initial release
// ============================================================================
module adc_scan_sequencer #(
    parameter int W       = 12,
    parameter int GAP     = 80,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [7:0]   ch_mask,
    input  logic         uni,
    output logic [5:0]   conf,
    output logic         start,
    input  logic [W-1:0] res,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic [2:0]   data_ch,
    output logic         data_valid,
    input  logic         data_ack,
    output logic         overrun,
    output logic         timeout,
    output logic         busy
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_issue   = 3'd1;
    localparam logic [2:0] c_st_wait    = 3'd2;
    localparam logic [2:0] c_st_capture = 3'd3;
    localparam logic [2:0] c_st_gap     = 3'd4;

    localparam int c_gw = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int c_tw = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_gw-1:0] c_gap_last = c_gw'(GAP - 1);
    localparam logic [c_tw-1:0] c_wd_last  = c_tw'(TIMEOUT - 1);

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic            r_issue_cnt;
    logic [c_tw-1:0] r_wd;
    logic [c_gw-1:0] r_gap_cnt;
    logic [2:0]      r_cur_ch;
    logic [2:0]      r_prev_ch;
    logic            r_prev_vld;
    logic            r_en_d;
    logic [5:0]      r_conf;
    logic [W-1:0]    r_data;
    logic [2:0]      r_data_ch;
    logic            r_data_valid;
    logic            r_overrun;
    logic            r_timeout;

    logic            w_go;
    logic            w_enter_issue;
    logic            w_timeout_hit;
    logic            w_load;
    logic [2:0]      w_pick_ch;

    // First set mask bit strictly after cur, wrapping; i=8 lands back on cur.
    function automatic logic [2:0] f_pick(input logic [2:0] cur, input logic [7:0] mask);
        logic [2:0] pick;
        logic [2:0] idx;
        logic       found;
        pick  = cur;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = cur + 3'(i);
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_go          = en && (ch_mask != 8'd0);
    assign w_enter_issue = (w_state_nxt == c_st_issue) && (r_state != c_st_issue);
    assign w_timeout_hit = (r_state == c_st_wait) && !ready && (r_wd == c_wd_last);
    assign w_load        = (r_state == c_st_capture) && r_prev_vld;
    assign w_pick_ch     = f_pick(r_cur_ch, ch_mask);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:    if (w_go) w_state_nxt = c_st_issue;
            c_st_issue:   if (r_issue_cnt) w_state_nxt = c_st_wait;
            c_st_wait: begin
                if (ready)                  w_state_nxt = c_st_capture;
                else if (r_wd == c_wd_last) w_state_nxt = c_st_gap;
            end
            c_st_capture: w_state_nxt = c_st_gap;
            c_st_gap: begin
                if (r_gap_cnt == c_gap_last) w_state_nxt = w_go ? c_st_issue : c_st_idle;
            end
            default:      w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        start = (r_state == c_st_issue);
        busy  = (r_state != c_st_idle);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_issue_cnt  <= 1'b0;
            r_wd         <= '0;
            r_gap_cnt    <= '0;
            r_cur_ch     <= 3'd7;
            r_prev_ch    <= 3'd0;
            r_prev_vld   <= 1'b0;
            r_en_d       <= 1'b0;
            r_conf       <= 6'd0;
            r_data       <= '0;
            r_data_ch    <= 3'd0;
            r_data_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_en_d      <= en;
            r_issue_cnt <= (r_state == c_st_issue) ? ~r_issue_cnt : 1'b0;
            r_wd        <= (r_state == c_st_wait) ? r_wd + 1'b1 : '0;
            r_gap_cnt   <= (r_state == c_st_gap) ? r_gap_cnt + 1'b1 : '0;

            if (w_enter_issue) begin
                r_cur_ch <= w_pick_ch;
                r_conf   <= {1'b1, w_pick_ch[0], w_pick_ch[2:1], uni, 1'b0};
            end

            // The result captured now belongs to the previous frame's channel.
            if (r_state == c_st_capture) begin
                r_prev_ch  <= r_cur_ch;
                r_prev_vld <= 1'b1;
            end else if (w_timeout_hit || (w_state_nxt == c_st_idle)) begin
                r_prev_vld <= 1'b0;
            end

            // Clear on en rising edge first so a same-cycle event still sets the flag.
            if (en && !r_en_d) begin
                r_overrun <= 1'b0;
                r_timeout <= 1'b0;
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
            if (w_load && r_data_valid && !data_ack) begin
                r_overrun <= 1'b1;
            end

            if (w_load) begin
                r_data       <= res;
                r_data_ch    <= r_prev_ch;
                r_data_valid <= 1'b1;
            end else if (data_ack) begin
                r_data_valid <= 1'b0;
            end
        end
    end

    assign conf       = r_conf;
    assign data       = r_data;
    assign data_ch    = r_data_ch;
    assign data_valid = r_data_valid;
    assign overrun    = r_overrun;
    assign timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_scan_sequencer
// Brief    : Randomized bench for adc_scan_sequencer with a frame-timeline
//            reference model and a few hand-computed anchor checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_scan_sequencer;

    localparam int W       = 12;
    localparam int GAP     = 6;
    localparam int TIMEOUT = 40;

    logic         clk = 1'b0;
    logic         rst, en, uni, ready, data_ack;
    logic [7:0]   ch_mask;
    logic [W-1:0] res;
    logic [5:0]   conf;
    logic         start, data_valid, overrun, timeout, busy;
    logic [W-1:0] data;
    logic [2:0]   data_ch;

    int n_checks = 0;
    int n_fail   = 0;

    adc_scan_sequencer #(.W(W), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask), .uni(uni),
        .conf(conf), .start(start), .res(res), .ready(ready),
        .data(data), .data_ch(data_ch), .data_valid(data_valid),
        .data_ack(data_ack), .overrun(overrun), .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- driver model ----------------
    int drv_lat = 0, lat_max = 4, res_cnt = 0;
    bit drv_pend = 0, drv_noready = 0;

    initial begin
        ready = 1'b0;
        res   = '0;
        forever begin
            @(posedge clk); #1;
            if (start) begin
                ready    = 1'b0;
                drv_pend = 1'b1;
                drv_lat  = $urandom_range(1, lat_max);
            end else if (drv_pend && !drv_noready) begin
                if (drv_lat <= 1) begin
                    res_cnt++;
                    res      = W'(res_cnt * 37);
                    ready    = 1'b1;
                    drv_pend = 1'b0;
                end else begin
                    drv_lat--;
                end
            end
        end
    end

    // ---------------- reference model (frame timeline) ----------------
    // m_t: clocks since the frame's first start cycle (-1 = idle);
    // m_cap: capture clock pending; m_gap: clocks spent in the inter-frame gap (-1 = none).
    int           m_t, m_gap, m_cur, m_prevch, m_dch;
    bit           m_cap, m_pv, m_valid, m_ovr, m_tmo, m_en_prev;
    logic [W-1:0] m_data;
    logic [5:0]   m_conf;

    task automatic m_reset();
        m_t = -1; m_gap = -1; m_cap = 0; m_pv = 0; m_valid = 0; m_ovr = 0; m_tmo = 0;
        m_en_prev = 0; m_cur = 7; m_prevch = 0; m_dch = 0; m_data = '0; m_conf = '0;
    endtask

    task automatic m_new_frame();
        logic [2:0] c;
        for (int i = 1; i <= 8; i++) begin
            if (ch_mask[(m_cur + i) % 8]) begin
                m_cur = (m_cur + i) % 8;
                break;
            end
        end
        c      = 3'(m_cur);
        m_conf = {1'b1, c[0], c[2:1], uni, 1'b0};
        m_t    = 0;
        m_gap  = -1;
        m_cap  = 0;
    endtask

    task automatic m_step();
        bit do_ack;
        if (!rst) begin
            m_reset();
            return;
        end
        do_ack = data_ack && m_valid;
        if (en && !m_en_prev) begin
            m_ovr = 0;
            m_tmo = 0;
        end
        if (m_gap >= 0) begin
            if (do_ack) m_valid = 0;
            if (m_gap == GAP - 1) begin
                if (en && ch_mask != 0) m_new_frame();
                else begin m_t = -1; m_gap = -1; m_pv = 0; end
            end else begin
                m_gap++;
            end
        end else if (m_cap) begin
            if (m_pv) begin
                if (m_valid && !data_ack) m_ovr = 1;
                m_data  = res;
                m_dch   = m_prevch;
                m_valid = 1;
            end else if (do_ack) begin
                m_valid = 0;
            end
            m_prevch = m_cur;
            m_pv     = 1;
            m_cap    = 0;
            m_gap    = 0;
        end else if (m_t >= 0) begin
            if (do_ack) m_valid = 0;
            if (m_t >= 2 && ready) m_cap = 1;
            else if (m_t == 1 + TIMEOUT) begin m_tmo = 1; m_pv = 0; m_gap = 0; end
            else m_t++;
        end else begin
            if (do_ack) m_valid = 0;
            if (en && ch_mask != 0) m_new_frame();
        end
        m_en_prev = en;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk);
            m_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("start", start, ((m_t == 0 || m_t == 1) && m_gap < 0 && !m_cap));
            chk("busy", busy, (m_t >= 0));
            chk("conf", conf, m_conf);
            chk("data_valid", data_valid, m_valid);
            chk("overrun", overrun, m_ovr);
            chk("timeout", timeout, m_tmo);
            if (m_valid) begin
                chk("data", data, m_data);
                chk("data_ch", data_ch, m_dch);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) tick();
        rst = 1'b1;
    endtask

    logic [5:0] confs[4];
    int         dchs[4];
    int         nc, nd, rises;
    bit         pstart;
    logic [5:0] exp_conf[4];
    int         exp_dch[4];

    initial begin
        rst = 1'b0; en = 1'b0; uni = 1'b0; ch_mask = 8'h00; data_ack = 1'b0;
        exp_conf[0] = 6'b100110; exp_conf[1] = 6'b111010;
        exp_conf[2] = 6'b111110; exp_conf[3] = 6'b100110;
        exp_dch[0] = 2; exp_dch[1] = 5; exp_dch[2] = 7; exp_dch[3] = 2;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_conf", conf, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b1;
        tick();

        // Empty mask with en=1 never starts a frame
        en = 1'b1; rises = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (start) rises++;
        end
        chk("mask0_starts", rises, 0);
        chk("mask0_busy", busy, 0);

        // Single channel: first frame discarded, second delivers res of frame 2
        en = 1'b0; lat_max = 3; data_ack = 1'b1;
        repeat (15) tick();
        res_cnt = 0; ch_mask = 8'h01; en = 1'b1; rises = 0; pstart = 0;
        for (int k = 0; k < 400 && !data_valid; k++) begin
            tick();
            if (start && !pstart) rises++;
            pstart = start;
        end
        chk("t1_frames_before_data", rises, 2);
        chk("t1_data", data, 74);
        chk("t1_data_ch", data_ch, 0);

        // Multi-channel conf and data_ch ordering
        en = 1'b0;
        do_reset(2);
        repeat (15) tick();
        ch_mask = 8'b1010_0100; uni = 1'b1; en = 1'b1; nc = 0; nd = 0; pstart = 0;
        for (int k = 0; k < 3000 && (nc < 4 || nd < 4); k++) begin
            tick();
            if (start && !pstart && nc < 4) begin confs[nc] = conf; nc++; end
            if (data_valid && nd < 4) begin dchs[nd] = data_ch; nd++; end
            pstart = start;
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_conf%0d", i), confs[i], exp_conf[i]);
            chk($sformatf("t2_dch%0d", i), dchs[i], exp_dch[i]);
        end

        // Overrun when the consumer stalls, then cleared by an en rising edge
        data_ack = 1'b0;
        for (int k = 0; k < 600 && !overrun; k++) tick();
        chk("t3_overrun", overrun, 1);
        chk("t3_valid", data_valid, 1);
        data_ack = 1'b1; en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        @(negedge clk);
        chk("t3_overrun_cleared", overrun, 0);

        // Watchdog expiry
        tick();
        drv_noready = 1'b1;
        for (int k = 0; k < 600 && !timeout; k++) tick();
        chk("t4_timeout", timeout, 1);
        drv_noready = 1'b0;
        repeat (200) tick();

        // en dropped while waiting for ready
        pstart = 0;
        for (int k = 0; k < 300 && !(pstart && !start); k++) begin
            pstart = start;
            tick();
        end
        en = 1'b0;
        for (int k = 0; k < 300 && busy; k++) tick();
        chk("t5_idle", busy, 0);
        en = 1'b1;
        repeat (100) tick();

        // Reset during ISSUE
        for (int k = 0; k < 300 && !start; k++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_start", start, 0);
        chk("t6_busy", busy, 0);
        chk("t6_valid", data_valid, 0);

        // Randomized traffic
        for (int k = 0; k < 6000; k++) begin
            tick();
            data_ack = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0) en = ~en;
            if ($urandom_range(0, 79) == 0)
                ch_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 59) == 0) uni = ~uni;
            if ($urandom_range(0, 99) == 0) lat_max = $urandom_range(1, 8);
            if (drv_noready) begin
                if ($urandom_range(0, 59) == 0) drv_noready = 1'b0;
            end else if ($urandom_range(0, 499) == 0) begin
                drv_noready = 1'b1;
            end
            rst = ($urandom_range(0, 1499) != 0);
        end
        rst = 1'b1;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
